spi_frame_master: RTL and testbench
===================================

// Module: spi_frame_master
// PURPOSE
//   SPI initiator (mode 0, MSB first) driving the sandpile chip's SPI responder.
//   Serialises one 16-bit config frame per request: {addr[3:0], data[11:0]}.
//   Captures POCI on the same edges, so loopback and readback can be checked.
//   Used in FPGA host logic and testbenches to program start/reset/grid_size/drop_mode/speed/seed.
// PARAMETERS
//   CLK_DIV  4   sys-clk cycles per SCLK half-period (>=1); 25 MHz/8 = 3.125 MHz SCLK
//   ADDR_W   4   address field width (frame MSBs)
//   DATA_W   12  data field width (frame LSBs)
//   GAP_HP   2   CS-high deselect time between frames, in half-periods (>=1)
// PORTS
//   clk         in   1                 system clock, all logic on rising edge
//   rst_n       in   1                 reset, synchronous and active-low
//   req_valid   in   1                 frame request
//   req_addr    in   ADDR_W            register address
//   req_data    in   DATA_W            register data
//   req_ready   out  1                 idle, can accept a request
//   rx_frame    out  ADDR_W+DATA_W     POCI bits of last frame, MSB first
//   done        out  1                 1-cycle pulse, frame complete, rx_frame valid
//   sclk        out  1                 SPI clock, idles low
//   cs          out  1                 chip select, active-low, idles high
//   pico        out  1                 serial data to responder
//   poci        in   1                 serial data from responder
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state IDLE, sclk=0, cs=1, pico=0, done=0,
//     req_ready=0, rx_frame=0, counters cleared. req_ready rises 1 cycle after release.
//   All outputs are registered. No combinational path from inputs to outputs.
//   Let N = ADDR_W+DATA_W = 16 and H = CLK_DIV.
//   Handshake: accept on clk edge with req_valid&req_ready. Latch addr/data into
//     shift reg. req_ready=0 the next cycle until the frame and gap finish.
//     req_valid while busy is ignored, with no queueing. Inputs are don't-care
//     after acceptance.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE: on accept, next cycle cs=0, pico=frame[N-1], go SETUP (half-period ctr=0).
//   SETUP: cs low, sclk low for H cycles, then SHIFT.
//   SHIFT: per bit, sclk low for H cycles, then high for H cycles.
//     On sclk 0->1 register update: rx shift <= {rx[N-2:0], poci}.
//     On sclk 1->0: shift left, pico = next bit; after bit N, sclk=0, pico held, go HOLD.
//     Exactly N rising SCLK edges per frame. Bit counter 0..N-1, no wrap past N-1.
//   HOLD: H cycles with sclk=0 and cs=0. Then cs=1, rx_frame<=rx shift,
//     done=1 for that one cycle, go GAP.
//   GAP: cs high for GAP_HP*H cycles, pico=0, then IDLE and req_ready=1.
//   Timing: cs low for exactly (2N+2)*H cycles (136 at defaults).
//     Accept to cs falling edge is 1 cycle.
//     Back-to-back cs-high time >= GAP_HP*H+1 cycles.
//   Mid-frame reset: the next cycle forces cs=1 and sclk=0. The frame is dropped,
//     with no done pulse and rx_frame=0. A responder sees the cs rise and discards
//     the partial frame.
//   CLK_DIV=1: SCLK = clk/2. Same FSM, every phase lasts 1 cycle.
// TESTING
//   T1 addr=4'h1, data=12'h0AB: pico sampled at SCLK rises = 0001_0000_1010_1011.
//      Exactly 16 rises. cs low 136 cycles. done 1 cycle after cs rise.
//   T2 loopback poci=pico, addr=4'hF, data=12'h5A3 -> rx_frame=16'hF5A3.
//      poci tied 0 -> 16'h0000.
//   T3 req_valid held high for two frames (4'h2/12'h010, then 4'h3/12'hFFF):
//      exactly 2 frames. cs high >= 9 cycles between them. No third frame.
//      The second frame is not corrupted.
//   T4 rst_n=0 for 1 cycle after the 7th SCLK rise:
//      next cycle cs=1, sclk=0. No done, rx_frame=0.
//      req_ready=1 one cycle after release. A new frame then completes normally.
//   T5 req_valid pulsed during SHIFT with different data: ignored.
//      pico stream and rx_frame match the original frame only.
//   T6 end-to-end with chip SPI responder, CLK_DIV=4 and CLK_DIV=1:
//      write addr=4'h4, data=12'h123 -> responder is_ready pulses once,
//      spi_address=4'h4, spi_data=12'h123.

Source files
------------

// File: rtl/spi_frame_master.sv
// SPI mode-0 initiator: one {addr,data} frame per request, MSB first, POCI captured on SCLK rises.
// Accept-to-CS-low is 1 cycle; req_ready stays low (requests ignored) until frame plus deselect gap finish.
module spi_frame_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 12,
  parameter int GAP_HP  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     req_ready,
  output logic [ADDR_W+DATA_W-1:0] rx_frame,
  output logic                     done,
  output logic                     sclk,
  output logic                     cs,
  output logic                     pico,
  input  logic                     poci
);

  localparam int N       = ADDR_W + DATA_W;
  localparam int GAP_CYC = GAP_HP * CLK_DIV;
  localparam int CNT_W   = $clog2(GAP_CYC + 1);
  localparam int BIT_W   = $clog2(N);
  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  // Holds only the bits still to be sent; the current bit already sits in pico.
  logic [N-2:0]     tx_sh, tx_nxt;
  logic [N-1:0]     rx_sh, rx_nxt;
  logic [N-1:0]     rx_frame_nxt;
  logic [N-1:0]     req_frame;
  logic             req_ready_nxt, done_nxt, sclk_nxt, cs_nxt, pico_nxt;
  logic             hp_end;

  assign req_frame = {req_addr, req_data};
  assign hp_end    = (cnt == HP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_frame  <= '0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      cs        <= 1'b1;
      pico      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      tx_sh     <= tx_nxt;
      rx_sh     <= rx_nxt;
      rx_frame  <= rx_frame_nxt;
      req_ready <= req_ready_nxt;
      done      <= done_nxt;
      sclk      <= sclk_nxt;
      cs        <= cs_nxt;
      pico      <= pico_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + CNT_W'(1);
    bit_cnt_nxt   = bit_cnt;
    tx_nxt        = tx_sh;
    rx_nxt        = rx_sh;
    rx_frame_nxt  = rx_frame;
    req_ready_nxt = 1'b0;
    done_nxt      = 1'b0;
    sclk_nxt      = sclk;
    cs_nxt        = cs;
    pico_nxt      = pico;

    case (state)
      IDLE: begin
        cnt_nxt       = '0;
        req_ready_nxt = 1'b1;
        cs_nxt        = 1'b1;
        sclk_nxt      = 1'b0;
        pico_nxt      = 1'b0;
        if (req_valid && req_ready) begin
          state_nxt     = SETUP;
          req_ready_nxt = 1'b0;
          cs_nxt        = 1'b0;
          tx_nxt        = req_frame[N-2:0];
          pico_nxt      = req_frame[N-1];
          bit_cnt_nxt   = '0;
          rx_nxt        = '0;
        end
      end
      SETUP: begin
        if (hp_end) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (hp_end) begin
          cnt_nxt = '0;
          if (!sclk) begin
            sclk_nxt = 1'b1;
            rx_nxt   = {rx_sh[N-2:0], poci};
          end else begin
            sclk_nxt = 1'b0;
            // Last bit: leave pico as-is through HOLD.
            if (bit_cnt == BIT_LAST) begin
              state_nxt = HOLD;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
              pico_nxt    = tx_sh[N-2];
              tx_nxt      = {tx_sh[N-3:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (hp_end) begin
          state_nxt    = GAP;
          cnt_nxt      = '0;
          cs_nxt       = 1'b1;
          done_nxt     = 1'b1;
          rx_frame_nxt = rx_sh;
          pico_nxt     = 1'b0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          req_ready_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: scoreboard of expected frames checked at each done pulse,
// plus a behavioural SPI responder on each instance (CLK_DIV=4 and CLK_DIV=1).
module tb_spi_frame_master;
  localparam int H       = 4;
  localparam int N       = 16;
  localparam int CS_LOW  = (2 * N + 2) * H;
  localparam int GAP_MIN = 2 * H + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [11:0] req_data = '0;
  logic        req_ready, done, sclk, cs, pico, poci;
  logic [15:0] rx_frame;
  logic        loop_en = 1'b1;
  logic        poci_fix = 1'b0;

  logic        req_valid1 = 1'b0;
  logic [3:0]  req_addr1 = '0;
  logic [11:0] req_data1 = '0;
  logic        req_ready1, done1, sclk1, cs1, pico1;
  logic [15:0] rx_frame1;

  assign poci = loop_en ? pico : poci_fix;

  spi_frame_master #(.CLK_DIV(H)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rx_frame(rx_frame), .done(done),
    .sclk(sclk), .cs(cs), .pico(pico), .poci(poci)
  );

  spi_frame_master #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_addr(req_addr1),
    .req_data(req_data1), .req_ready(req_ready1), .rx_frame(rx_frame1), .done(done1),
    .sclk(sclk1), .cs(cs1), .pico(pico1), .poci(pico1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_tx_q[$];
  logic [15:0] exp_rx_q[$];

  // Behavioural responders: latch a write only when exactly 16 bits arrived under CS.
  int r0_n = 0, r0_cnt = 0, r1_n = 0, r1_cnt = 0;
  logic [15:0] r0_sh = '0, r1_sh = '0;
  always @(negedge cs) r0_n = 0;
  always @(posedge sclk) if (cs === 1'b0) begin r0_sh = {r0_sh[14:0], pico}; r0_n++; end
  always @(posedge cs) if (r0_n == 16) r0_cnt++;
  always @(negedge cs1) r1_n = 0;
  always @(posedge sclk1) if (cs1 === 1'b0) begin r1_sh = {r1_sh[14:0], pico1}; r1_n++; end
  always @(posedge cs1) if (r1_n == 16) r1_cnt++;

  // Monitor for u0, sampled on the falling clock edge.
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, after_done = 1'b0;
  int          low_cnt = 0, high_cnt = 0, rises = 0, done_cnt = 0;
  logic [15:0] bits = '0;
  logic [15:0] exp_tx, exp_rx;

  always @(negedge clk) begin
    if (cs === 1'b0 && prev_cs) begin
      if (after_done) check("cs_gap_ge_min", 32'(high_cnt >= GAP_MIN), 32'h1);
      low_cnt = 1;
      rises   = 0;
    end else if (cs === 1'b0) begin
      low_cnt++;
    end
    if (cs === 1'b1 && !prev_cs) begin
      high_cnt   = 1;
      after_done = done;
    end else if (cs === 1'b1) begin
      high_cnt++;
    end
    if (sclk === 1'b1 && !prev_sclk) begin
      bits = {bits[14:0], pico};
      rises++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_with_cs_rise", 32'({prev_cs, cs}), 32'h1);
      check("frame_expected", 32'(exp_tx_q.size() != 0), 32'h1);
      if (exp_tx_q.size() != 0) begin
        exp_tx = exp_tx_q.pop_front();
        exp_rx = exp_rx_q.pop_front();
        check("pico_stream", 32'(bits), 32'(exp_tx));
        check("rx_frame", 32'(rx_frame), 32'(exp_rx));
        check("sclk_rises", 32'(rises), 32'(N));
        check("cs_low_cycles", 32'(low_cnt), 32'(CS_LOW));
      end
    end
    prev_cs   = (cs === 1'b1);
    prev_sclk = (sclk === 1'b1);
  end

  task automatic send(input logic [3:0] a, input logic [11:0] d, input bit keep);
    int n;
    @(negedge clk);
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    exp_tx_q.push_back({a, d});
    exp_rx_q.push_back(loop_en ? {a, d} : {16{poci_fix}});
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_tx_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check("drain_empty", 32'(exp_tx_q.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic wait_rises(input int target);
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (rises < target && n < 2000);
    if (rises < target) check("rise_timeout", 32'(rises), 32'(target));
  endtask

  int d0, r0_before, low1, n1;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(cs), 32'h1);
    check("rst_sclk", 32'(sclk), 32'h0);
    check("rst_pico", 32'(pico), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rx_frame", 32'(rx_frame), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 32'h1);

    // T1: pico pattern, POCI tied high
    loop_en = 1'b0; poci_fix = 1'b1;
    send(4'h1, 12'h0AB, 1'b0);
    drain();

    // T2: loopback, then POCI tied low
    loop_en = 1'b1;
    send(4'hF, 12'h5A3, 1'b0);
    drain();
    loop_en = 1'b0; poci_fix = 1'b0;
    send(4'hF, 12'h5A3, 1'b0);
    drain();

    // T3: req_valid held across two frames
    loop_en = 1'b1;
    d0 = done_cnt;
    send(4'h2, 12'h010, 1'b1);
    send(4'h3, 12'hFFF, 1'b0);
    drain();
    repeat (300) @(negedge clk);
    check("two_frames_only", 32'(done_cnt - d0), 32'h2);

    // T4: reset after the 7th SCLK rise
    send(4'h6, 12'h789, 1'b0);
    wait_rises(7);
    void'(exp_tx_q.pop_back());
    void'(exp_rx_q.pop_back());
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs", 32'(cs), 32'h1);
    check("abort_sclk", 32'(sclk), 32'h0);
    check("abort_rx_frame", 32'(rx_frame), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", 32'(req_ready), 32'h1);
    send(4'hA, 12'h5C3, 1'b0);
    drain();
    check("abort_no_done", 32'(done_cnt - d0), 32'h1);

    // T5: request pulse during SHIFT is ignored
    d0 = done_cnt;
    send(4'h5, 12'h0C3, 1'b0);
    wait_rises(3);
    @(negedge clk);
    req_addr = 4'hE; req_data = 12'hEEE; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    drain();
    repeat (200) @(negedge clk);
    check("busy_request_ignored", 32'(done_cnt - d0), 32'h1);

    // T6: responder write, CLK_DIV=4
    r0_before = r0_cnt;
    send(4'h4, 12'h123, 1'b0);
    drain();
    check("resp0_ready_once", 32'(r0_cnt - r0_before), 32'h1);
    check("resp0_frame", 32'(r0_sh), 32'h4123);

    // T6: responder write, CLK_DIV=1
    @(negedge clk);
    req_addr1 = 4'h4; req_data1 = 12'h123; req_valid1 = 1'b1;
    n1 = 0;
    while (!req_ready1 && n1 < 100) begin @(negedge clk); n1++; end
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    low1 = 0; n1 = 0;
    do begin
      @(negedge clk);
      if (cs1 === 1'b0) low1++;
      n1++;
    end while (done1 !== 1'b1 && n1 < 500);
    check("div1_done", 32'(done1), 32'h1);
    check("div1_cs_low", 32'(low1), 32'(2 * N + 2));
    check("div1_rx_frame", 32'(rx_frame1), 32'h4123);
    @(negedge clk);
    check("resp1_ready_once", 32'(r1_cnt), 32'h1);
    check("resp1_frame", 32'(r1_sh), 32'h4123);

    check("resp0_total", 32'(r0_cnt), 32'(done_cnt));
    check("queue_empty", 32'(exp_tx_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
